// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline register with skid entry.
// Registered in_ready, synchronous flush, saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE      = '0,
  parameter int unsigned       STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  state_t                   state_q;
  state_t                   state_n;
  logic [DATA_W-1:0]        main_q;
  logic [DATA_W-1:0]        main_n;
  logic [DATA_W-1:0]        skid_q;
  logic [DATA_W-1:0]        skid_n;
  logic                     rdy_q;
  logic                     rdy_n;
  logic [STALL_CNT_W-1:0]   stall_q;
  logic                     acc;
  logic                     con;
  logic                     stall;

  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = rdy_q;
  assign stall_cnt = stall_q;

  // Only the valid main entry reaches the port; invalid shows the bubble.
  assign out_data = out_valid ? main_q : BUBBLE;

  assign acc   = in_valid & rdy_q;
  assign con   = out_valid & out_ready;
  assign stall = out_valid & ~out_ready;

  // Next state and data for the main/skid pair; flush wins over handshakes.
  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = S_EMPTY;
      main_n  = BUBBLE;
      skid_n  = BUBBLE;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (acc) begin
            main_n  = in_data;
            state_n = S_BUSY;
          end
        end
        S_BUSY: begin
          unique case (1'b1)
            (acc & con): begin
              main_n = in_data;
            end
            (con & ~acc): begin
              main_n  = BUBBLE;
              state_n = S_EMPTY;
            end
            (acc & ~con): begin
              skid_n  = in_data;
              state_n = S_FULL;
            end
            default: ;
          endcase
        end
        S_FULL: begin
          if (con) begin
            main_n  = skid_q;
            skid_n  = BUBBLE;
            state_n = S_BUSY;
          end
        end
        default: begin
          state_n = S_EMPTY;
          main_n  = BUBBLE;
          skid_n  = BUBBLE;
        end
      endcase
    end
    rdy_n = (state_n != S_FULL);
  end

  // State, payload and ready registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      main_q  <= main_n;
      skid_q  <= skid_n;
      rdy_q   <= rdy_n;
    end
  end

  // Stall counter saturates and ignores flush.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_q <= '0;
    end else if (stall && (stall_q != STALL_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule
